food_spawner: RTL
=================

// Module: food_spawner
// PURPOSE
// - Consumes the free-running 7-bit LFSR coordinates (rand_x/rand_y) and turns them into a legal food cell.
// - Reduces the random values into grid range and checks each candidate against snake-body occupancy via a query handshake.
// - Retries on a hit, then falls back to a linear scan; publishes food_x/food_y to the game FSM and renderer.
// PARAMETERS
// - COORD_W    7    width of rand_x/rand_y and coordinate ports
// - GRID_W     40   playfield width in cells; legal x = 0..GRID_W-1
// - GRID_H     30   playfield height in cells; legal y = 0..GRID_H-1
// - MAX_TRIES  16   random candidates tried before the linear-scan fallback
// PORTS
// - clk              in   1        clock, rising edge
// - rst              in   1        reset, synchronous, active-high
// - spawn_req        in   1        request new food; accepted only in IDLE
// - rand_x           in   COORD_W  random x from LFSR source
// - rand_y           in   COORD_W  random y from LFSR source
// - occ_query_valid  out  1        occupancy query valid; coordinates held stable while high
// - occ_query_x      out  COORD_W  cell x being queried
// - occ_query_y      out  COORD_W  cell y being queried
// - occ_resp_valid   in   1        occupancy answer valid; may be asserted in the same cycle as the query
// - occ_hit          in   1        1 = cell occupied by snake; qualified by occ_resp_valid
// - food_x           out  COORD_W  placed food x
// - food_y           out  COORD_W  placed food y
// - food_valid       out  1        food_x/food_y hold a legal free cell
// - busy             out  1        spawn in progress
// - spawn_fail       out  1        one-cycle pulse: no free cell exists
// BEHAVIOUR
// - Reset: all outputs 0 (food_x, food_y, food_valid, busy, spawn_fail, occ_query_*); state IDLE; tries and scan_cnt 0.
// - rst mid-spawn aborts; reset values apply from the next cycle.
// - IDLE
//   - On spawn_req: latch rand_x/rand_y into cand_x/cand_y; clear food_valid, tries and scan_cnt; set busy; go to REDUCE.
//   - spawn_req while busy is ignored, with no queuing.
// - REDUCE, one step per cycle:
//   - If cand_x>=GRID_W, subtract GRID_W. If cand_y>=GRID_H, subtract GRID_H.
//   - Leave for QUERY in the cycle both are already in range; an in-range sample spends exactly 1 cycle here.
//   - Worst case is ceil(2^COORD_W/min(GRID_W,GRID_H)) cycles.
// - QUERY
//   - occ_query_valid=1 and occ_query_x/y=cand. Wait for occ_resp_valid; occ_resp_valid seen while occ_query_valid=0 is ignored.
//   - Free (occ_hit=0): food_x/y<=cand; food_valid<=1; busy<=0; go to IDLE.
//   - Hit, random phase: tries++. If tries<MAX_TRIES, relatch rand_x/rand_y and go to REDUCE. Otherwise go to SCAN.
//   - Hit, scan phase: scan_cnt++. If scan_cnt==GRID_W*GRID_H, go to FAIL. Otherwise go to SCAN.
// - SCAN (1 cycle): step to the next cell, then go to QUERY.
//   - cand_x++; on GRID_W-1 wrap x to 0 and increment y.
//   - On y==GRID_H-1 with the x wrap, y wraps to 0.
// - FAIL: spawn_fail=1 for 1 cycle; food_valid stays 0; busy<=0; go to IDLE.
// - occ_query_valid drops for at least 1 cycle between consecutive queries.
// - Latency, free first candidate with same-cycle response:
//   - spawn_req sampled at cycle 0.
//   - REDUCE at cycle 1, QUERY at cycle 2.
//   - food_valid=1 from cycle 3.
// - food_valid/food_x/food_y stay stable until the next accepted spawn_req.
// - Widths:
//   - scan_cnt is clog2(GRID_W*GRID_H+1) bits; tries is clog2(MAX_TRIES+1) bits.
//   - Subtractions are done at COORD_W bits with no wrap below 0; guard on >= before subtracting.
// STRUCTURE
// - snake_pkg holds GRID_W, GRID_H, COORD_W and the spawner state enum (IDLE, REDUCE, QUERY, SCAN, FAIL), shared with the game FSM.
// - One sub-module, coord_reduce: the per-axis iterative subtract with a done flag, instantiated for x and for y.
// - FSM, counters and output registers stay in food_spawner.
// TESTING
// - In-range sample: rand=(10,5), same-cycle free response -> query (10,5) at cycle 2; food=(10,5), food_valid=1 at cycle 3.
// - Reduction: rand=(127,100) -> 3 REDUCE steps for x (to 7) and y (to 10); query at (7,10).
// - Occupied retry: first response hit, second candidate (3,4) free -> tries=1; food=(3,4).
// - Scan fallback:
//   - Stimulus: 16 random hits, last candidate (39,29); cell (0,0) free.
//   - Expect: SCAN wraps to (0,0); food=(0,0).
// - Full board: every response hit -> 16 random queries + 1200 scan queries; spawn_fail pulses once; food_valid=0.
// - Protocol and reset:
//   - Delay occ_resp_valid by 5 cycles -> query coordinates stable throughout.
//   - spawn_req while busy -> ignored.
//   - rst asserted in QUERY -> all outputs 0 next cycle.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared snake-game constants and the food spawner state encoding.
// The game FSM imports this package as well.
package snake_pkg;

  localparam int unsigned COORD_W = 7;
  localparam int unsigned GRID_W  = 40;
  localparam int unsigned GRID_H  = 30;

  typedef enum logic [2:0] {
    StIdle,
    StReduce,
    StQuery,
    StScan,
    StFail
  } spawn_state_e;

endpackage

// File: rtl/coord_reduce.sv
// One step of the iterative modulo for a single axis.
// Subtracts LIMIT only when the value is out of range, so the result never wraps below zero.
module coord_reduce
  import snake_pkg::*;
#(
  parameter int unsigned LIMIT = GRID_W
) (
  input  logic [COORD_W-1:0] val,
  output logic [COORD_W-1:0] next_val,
  output logic               done
);

  localparam logic [COORD_W-1:0] Lim = COORD_W'(LIMIT);

  assign done     = (val < Lim);
  assign next_val = done ? val : val - Lim;

endmodule

// File: rtl/food_spawner.sv
// Turns free-running LFSR coordinates into a free food cell on the playfield.
// Random candidates are tried first; after repeated hits it falls back to a linear scan.
module food_spawner
  import snake_pkg::*;
#(
  parameter int unsigned MAX_TRIES = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               spawn_req,
  input  logic [COORD_W-1:0] rand_x,
  input  logic [COORD_W-1:0] rand_y,
  output logic               occ_query_valid,
  output logic [COORD_W-1:0] occ_query_x,
  output logic [COORD_W-1:0] occ_query_y,
  input  logic               occ_resp_valid,
  input  logic               occ_hit,
  output logic [COORD_W-1:0] food_x,
  output logic [COORD_W-1:0] food_y,
  output logic               food_valid,
  output logic               busy,
  output logic               spawn_fail
);

  localparam int unsigned Cells  = GRID_W * GRID_H;
  localparam int unsigned ScanW  = $clog2(Cells + 1);
  localparam int unsigned TriesW = $clog2(MAX_TRIES + 1);

  localparam logic [COORD_W-1:0] XLast = COORD_W'(GRID_W - 1);
  localparam logic [COORD_W-1:0] YLast = COORD_W'(GRID_H - 1);

  spawn_state_e       state_q, state_d;
  logic [COORD_W-1:0] cand_x_q, cand_x_d, cand_y_q, cand_y_d;
  logic [COORD_W-1:0] food_x_q, food_x_d, food_y_q, food_y_d;
  logic               food_valid_q, food_valid_d;
  logic [TriesW-1:0]  tries_q, tries_d, tries_inc;
  logic [ScanW-1:0]   scan_cnt_q, scan_cnt_d, scan_inc;

  logic [COORD_W-1:0] red_x, red_y;
  logic               x_done, y_done;
  logic               scan_phase;

  coord_reduce #(
    .LIMIT(GRID_W)
  ) u_reduce_x (
    .val     (cand_x_q),
    .next_val(red_x),
    .done    (x_done)
  );

  coord_reduce #(
    .LIMIT(GRID_H)
  ) u_reduce_y (
    .val     (cand_y_q),
    .next_val(red_y),
    .done    (y_done)
  );

  assign tries_inc  = tries_q + TriesW'(1);
  assign scan_inc   = scan_cnt_q + ScanW'(1);
  // Random phase is over once every try has been spent.
  assign scan_phase = (tries_q == TriesW'(MAX_TRIES));

  always_comb begin
    state_d      = state_q;
    cand_x_d     = cand_x_q;
    cand_y_d     = cand_y_q;
    food_x_d     = food_x_q;
    food_y_d     = food_y_q;
    food_valid_d = food_valid_q;
    tries_d      = tries_q;
    scan_cnt_d   = scan_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (spawn_req) begin
          cand_x_d     = rand_x;
          cand_y_d     = rand_y;
          food_valid_d = 1'b0;
          tries_d      = '0;
          scan_cnt_d   = '0;
          state_d      = StReduce;
        end
      end
      StReduce: begin
        if (x_done && y_done) begin
          state_d = StQuery;
        end else begin
          cand_x_d = red_x;
          cand_y_d = red_y;
        end
      end
      StQuery: begin
        if (occ_resp_valid) begin
          if (!occ_hit) begin
            food_x_d     = cand_x_q;
            food_y_d     = cand_y_q;
            food_valid_d = 1'b1;
            state_d      = StIdle;
          end else if (!scan_phase) begin
            tries_d = tries_inc;
            if (tries_inc < TriesW'(MAX_TRIES)) begin
              cand_x_d = rand_x;
              cand_y_d = rand_y;
              state_d  = StReduce;
            end else begin
              state_d = StScan;
            end
          end else begin
            scan_cnt_d = scan_inc;
            state_d    = (scan_inc == ScanW'(Cells)) ? StFail : StScan;
          end
        end
      end
      StScan: begin
        if (cand_x_q == XLast) begin
          cand_x_d = '0;
          cand_y_d = (cand_y_q == YLast) ? '0 : cand_y_q + COORD_W'(1);
        end else begin
          cand_x_d = cand_x_q + COORD_W'(1);
        end
        state_d = StQuery;
      end
      StFail: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cand_x_q     <= '0;
      cand_y_q     <= '0;
      food_x_q     <= '0;
      food_y_q     <= '0;
      food_valid_q <= 1'b0;
      tries_q      <= '0;
      scan_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      cand_x_q     <= cand_x_d;
      cand_y_q     <= cand_y_d;
      food_x_q     <= food_x_d;
      food_y_q     <= food_y_d;
      food_valid_q <= food_valid_d;
      tries_q      <= tries_d;
      scan_cnt_q   <= scan_cnt_d;
    end
  end

  // Leaving QUERY always passes through another state, so valid drops between queries.
  assign occ_query_valid = (state_q == StQuery);
  assign occ_query_x     = occ_query_valid ? cand_x_q : '0;
  assign occ_query_y     = occ_query_valid ? cand_y_q : '0;
  assign food_x          = food_x_q;
  assign food_y          = food_y_q;
  assign food_valid      = food_valid_q;
  assign busy            = (state_q != StIdle);
  assign spawn_fail      = (state_q == StFail);

endmodule
